valu_seq: RTL and testbench
===========================

Name: valu_seq

Overview:
- Vector-instruction sequencer for the 32-bit element ALU.
- Accepts one vector arithmetic command at a time: opcode, two source registers, one destination register and a vector length.
- Walks elements 0..vl-1: reads operand pairs from the vector register file (VRF), drives the ALU, writes each result back.
- Sits between the vector issue stage and the VRF/ALU; throughput is one element per cycle.

Parameters:
- NUM_REGS, 32, number of vector registers; REG_W = $clog2(NUM_REGS).
- MAX_VL, 8, maximum elements per register; ELEM_W = $clog2(MAX_VL), VL_W = $clog2(MAX_VL+1).

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer idle, can accept.
- cmd_op  in  9  opcode.
- cmd_vs1, cmd_vs2, cmd_vd  in  REG_W each  source A, source B, destination register.
- cmd_vl  in  VL_W  element count.
- rd_en  out  1  VRF read strobe.
- rd_reg_a, rd_reg_b  out  REG_W  read register indices.
- rd_elem  out  ELEM_W  element index (shared by both read ports).
- rd_data_a, rd_data_b  in  32  VRF data, valid exactly 1 cycle after rd_en.
- alu_en  out  1  ALU enable.
- alu_op  out  9  ALU opcode.
- alu_a, alu_b  out  32  ALU operands.
- alu_res  in  32  ALU result (combinational).
- wr_en  out  1  VRF write strobe.
- wr_reg  out  REG_W  write register index.
- wr_elem  out  ELEM_W  write element index.
- wr_data  out  32  write data.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done; 1 = command rejected.

Behaviour:
- Reset nrst: synchronous, active-low. While low:
  - state=IDLE; all strobes (rd_en, alu_en, wr_en, done, err) = 0.
  - All index/data outputs = 0; cmd_ready = 0.
  - The cycle after nrst rises, cmd_ready = 1.
- Legal opcodes:
  - 9'h000, 9'h004 = add (result mod 2^32).
  - 9'h0B9, 9'h0BC = multiply (low 32 bits of the product).
  - Every other value is illegal.
- Handshake:
  - A command is accepted on a cycle where cmd_valid && cmd_ready.
  - Command fields are latched at acceptance; cmd_ready = (state==IDLE).
- States: IDLE, RUN, DRAIN, RESP.
  - IDLE -> RUN on accept with a legal op and 0 < vl <= MAX_VL.
  - IDLE -> RESP on accept with an illegal op or vl > MAX_VL; err=1, no reads, no writes.
  - IDLE -> RESP on accept with vl == 0; err=0, no reads, no writes.
  - RUN: rd_en=1, rd_elem=i (i from 0), rd_reg_a=vs1, rd_reg_b=vs2, i++ each cycle. After issuing i=vl-1 -> DRAIN.
  - Write stage (RUN cycles after the first, plus DRAIN): data returned for element j drives alu_a/alu_b with alu_en=1 and alu_op=latched op. Same cycle: wr_en=1, wr_reg=vd, wr_elem=j, wr_data=alu_res.
  - DRAIN: performs the final write -> RESP.
  - RESP: done=1 for one cycle -> IDLE.
- Timing, accept at cycle T with vl=N:
  - Reads in T+1..T+N; writes in T+2..T+N+1; done at T+N+2.
  - cmd_ready high again at T+N+3.
  - Rejected or vl=0 command: done at T+1.
- alu_a, alu_b, alu_op are held at their last value when alu_en=0.
- Aliasing (vd equal to vs1 and/or vs2): correct without stalls. Write of element j-1 and read of element j never target the same element.
- Reset mid-command: sequence aborts immediately. No further wr_en, no done; the command is lost.
- cmd_valid while busy is ignored (cmd_ready=0), with no side effects.

Decomposition:
- Shared package valu_pkg holds:
  - Opcode constants: OP_ADD0=9'h000, OP_ADD1=9'h004, OP_MUL0=9'h0B9, OP_MUL1=9'h0BC.
  - Function is_legal_op.
  - State enum seq_state_t.
  - Default NUM_REGS/MAX_VL.
- No sub-module is required. The ALU stays external so it can be shared; valu_seq instantiates nothing.

Test Plan:
- Add, op=9'h000, vs1=1, vs2=2, vd=3, vl=4; VRF r1={1,2,3,4}, r2={10,20,30,40} -> r3={11,22,33,44}; writes at T+2..T+5, done at T+6, err=0.
- Multiply, op=9'h0BC, vl=8; r1[k]=32'h0001_0000, r2[k]=32'h0001_0001 -> every r3[k]=32'h0001_0000 (truncation); 8 back-to-back writes, done at T+10.
- Illegal op 9'h001 and, separately, vl=MAX_VL+1 -> done+err at T+1; rd_en and wr_en never asserted.
- vl=0 with legal op -> done=1, err=0 at T+1; no reads or writes; next command accepted at T+2.
- Aliasing, vd=vs1=5, add, r5={1,1,1,1}, r6={2,2,2,2} -> r5={3,3,3,3}; cmd_valid held high while busy does not cause a second accept.
- nrst low at write 2 of a vl=8 add -> no further wr_en or done; outputs zero; next command runs normally.

Source files
------------

// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU sequencer: opcodes, FSM state type,
// default geometry and the opcode legality check.
package valu_pkg;

   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_MAX_VL   = 8;
   localparam int OP_W         = 9;
   localparam int DATA_W       = 32;

   localparam logic [OP_W-1:0] OP_ADD0 = 9'h000;
   localparam logic [OP_W-1:0] OP_ADD1 = 9'h004;
   localparam logic [OP_W-1:0] OP_MUL0 = 9'h0B9;
   localparam logic [OP_W-1:0] OP_MUL1 = 9'h0BC;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      RESP
   } seq_state_t;

   // True for the opcodes the element ALU implements.
   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return (op == OP_ADD0) || (op == OP_ADD1) ||
             (op == OP_MUL0) || (op == OP_MUL1);
   endfunction

endpackage

// File: rtl/valu_seq_if.sv
// Command channel from the vector issue stage into the sequencer.
// The issue stage is the master; the sequencer is the slave.
interface valu_seq_if
   import valu_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int MAX_VL   = DEF_MAX_VL
);
   localparam int REG_W = $clog2(NUM_REGS);
   localparam int VL_W  = $clog2(MAX_VL + 1);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [OP_W-1:0]  cmd_op;
   logic [REG_W-1:0] cmd_vs1;
   logic [REG_W-1:0] cmd_vs2;
   logic [REG_W-1:0] cmd_vd;
   logic [VL_W-1:0]  cmd_vl;

   modport master (
      output cmd_valid, cmd_op, cmd_vs1, cmd_vs2, cmd_vd, cmd_vl,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_vs1, cmd_vs2, cmd_vd, cmd_vl,
      output cmd_ready
   );

endinterface

// File: rtl/valu_seq.sv
// Vector-instruction sequencer: accepts one command, streams element pairs
// out of the VRF one per cycle, feeds the shared external ALU and writes each
// result back one cycle after its read. done/err report completion.
module valu_seq
   import valu_pkg::*;
#(
   parameter  int NUM_REGS = DEF_NUM_REGS,
   parameter  int MAX_VL   = DEF_MAX_VL,
   localparam int REG_W    = $clog2(NUM_REGS),
   localparam int ELEM_W   = $clog2(MAX_VL),
   localparam int VL_W     = $clog2(MAX_VL + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   valu_seq_if.slave         cmd,
   // VRF read port
   output logic              rd_en,
   output logic [REG_W-1:0]  rd_reg_a,
   output logic [REG_W-1:0]  rd_reg_b,
   output logic [ELEM_W-1:0] rd_elem,
   input  logic [DATA_W-1:0] rd_data_a,
   input  logic [DATA_W-1:0] rd_data_b,
   // External element ALU
   output logic              alu_en,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_res,
   // VRF write port
   output logic              wr_en,
   output logic [REG_W-1:0]  wr_reg,
   output logic [ELEM_W-1:0] wr_elem,
   output logic [DATA_W-1:0] wr_data,
   // Completion
   output logic              done,
   output logic              err
);

   seq_state_t        state;
   logic              ready_q;
   logic [OP_W-1:0]   op_q;
   logic [ELEM_W-1:0] last_elem;
   logic [OP_W-1:0]   alu_op_hold;
   logic [DATA_W-1:0] alu_a_hold;
   logic [DATA_W-1:0] alu_b_hold;
   logic              accept;
   logic              cmd_bad;
   logic              cmd_empty;

   assign cmd.cmd_ready = ready_q;

   assign accept    = cmd.cmd_valid && ready_q;
   assign cmd_bad   = !is_legal_op(cmd.cmd_op) || (cmd.cmd_vl > VL_W'(MAX_VL));
   assign cmd_empty = (cmd.cmd_vl == '0);

   // Write stage: VRF data arrives one cycle after its read strobe and goes
   // straight through the ALU into the write port in that same cycle.
   // NOTE: outside the write stage the ALU inputs come from explicit hold
   // registers, so every output has a value on every path and no latch forms.
   assign alu_en  = wr_en;
   assign alu_op  = wr_en ? op_q      : alu_op_hold;
   assign alu_a   = wr_en ? rd_data_a : alu_a_hold;
   assign alu_b   = wr_en ? rd_data_b : alu_b_hold;
   assign wr_data = wr_en ? alu_res   : '0;

   // Remember the last operands/opcode shown to the ALU so they stay stable while idle.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         alu_op_hold <= '0;
         alu_a_hold  <= '0;
         alu_b_hold  <= '0;
      end else begin
         alu_op_hold <= alu_op;
         alu_a_hold  <= alu_a;
         alu_b_hold  <= alu_b;
      end
   end

   // Sequencer FSM with registered strobes, indices and response.
   // NOTE: every register here uses non-blocking assignment so that the
   // read-to-write pipeline (wr_en <= rd_en) sees the pre-edge values.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state     <= IDLE;
         ready_q   <= 1'b0;
         op_q      <= '0;
         last_elem <= '0;
         rd_en     <= 1'b0;
         rd_reg_a  <= '0;
         rd_reg_b  <= '0;
         rd_elem   <= '0;
         wr_en     <= 1'b0;
         wr_reg    <= '0;
         wr_elem   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         // Write stage trails the read stage by exactly one cycle.
         wr_en   <= rd_en;
         wr_elem <= rd_elem;
         done    <= 1'b0;
         err     <= 1'b0;

         case (state)
            IDLE: begin
               ready_q <= 1'b1;
               if (accept) begin
                  ready_q   <= 1'b0;
                  op_q      <= cmd.cmd_op;
                  rd_reg_a  <= cmd.cmd_vs1;
                  rd_reg_b  <= cmd.cmd_vs2;
                  wr_reg    <= cmd.cmd_vd;
                  last_elem <= ELEM_W'(cmd.cmd_vl - 1'b1);
                  if (cmd_bad) begin
                     state <= RESP;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (cmd_empty) begin
                     state <= RESP;
                     done  <= 1'b1;
                  end else begin
                     state   <= RUN;
                     rd_en   <= 1'b1;
                     rd_elem <= '0;
                  end
               end
            end

            RUN: begin
               if (rd_elem == last_elem) begin
                  rd_en <= 1'b0;
                  state <= DRAIN;
               end else begin
                  rd_elem <= rd_elem + 1'b1;
               end
            end

            // Last element is being written this cycle; respond next.
            DRAIN: begin
               state <= RESP;
               done  <= 1'b1;
            end

            RESP: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end

            default: begin
               state   <= IDLE;
               ready_q <= 1'b0;
               rd_en   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_valu_seq.sv
// Randomized and directed bench for valu_seq. The bench owns the VRF and the
// ALU; a separate reference VRF is updated from the arithmetic rules and the
// cycle schedule of each command is checked against the expected timeline.
module tb_valu_seq;
   import valu_pkg::*;

   localparam int NUM_REGS = 32;
   localparam int MAX_VL   = 8;
   localparam int REG_W    = 5;
   localparam int ELEM_W   = 3;

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic              rd_en;
   logic [REG_W-1:0]  rd_reg_a, rd_reg_b;
   logic [ELEM_W-1:0] rd_elem;
   logic [31:0]       rd_data_a = '0;
   logic [31:0]       rd_data_b = '0;
   logic              alu_en;
   logic [8:0]        alu_op;
   logic [31:0]       alu_a, alu_b, alu_res;
   logic              wr_en;
   logic [REG_W-1:0]  wr_reg;
   logic [ELEM_W-1:0] wr_elem;
   logic [31:0]       wr_data;
   logic              done, err;

   logic [31:0] vrf     [NUM_REGS][MAX_VL];
   logic [31:0] ref_vrf [NUM_REGS][MAX_VL];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   valu_seq_if #(.NUM_REGS(NUM_REGS), .MAX_VL(MAX_VL)) cmd_if ();

   valu_seq #(.NUM_REGS(NUM_REGS), .MAX_VL(MAX_VL)) dut (
      .clk      (clk),
      .nrst     (nrst),
      .cmd      (cmd_if.slave),
      .rd_en    (rd_en),
      .rd_reg_a (rd_reg_a),
      .rd_reg_b (rd_reg_b),
      .rd_elem  (rd_elem),
      .rd_data_a(rd_data_a),
      .rd_data_b(rd_data_b),
      .alu_en   (alu_en),
      .alu_op   (alu_op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_res  (alu_res),
      .wr_en    (wr_en),
      .wr_reg   (wr_reg),
      .wr_elem  (wr_elem),
      .wr_data  (wr_data),
      .done     (done),
      .err      (err)
   );

   // VRF: read data one cycle after rd_en, writes on the clock edge.
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data_a <= vrf[rd_reg_a][rd_elem];
         rd_data_b <= vrf[rd_reg_b][rd_elem];
      end
      if (wr_en) vrf[wr_reg][wr_elem] <= wr_data;
   end

   // Combinational element ALU.
   always_comb begin
      case (alu_op)
         9'h000, 9'h004: alu_res = alu_a + alu_b;
         9'h0B9, 9'h0BC: alu_res = alu_a * alu_b;
         default:        alu_res = '0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit op_is_add(input logic [8:0] op);
      return op == 9'h000 || op == 9'h004;
   endfunction

   function automatic bit op_is_mul(input logic [8:0] op);
      return op == 9'h0B9 || op == 9'h0BC;
   endfunction

   function automatic logic [31:0] ref_elem(input logic [8:0] op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned ua, ub, p;
      ua = 64'(a);
      ub = 64'(b);
      p  = op_is_add(op) ? ua + ub : ua * ub;
      return p[31:0];
   endfunction

   // Compare the whole bench VRF against the reference VRF.
   task automatic check_vrf(input string tag);
      int bad = 0;
      for (int r = 0; r < NUM_REGS; r++)
         for (int e = 0; e < MAX_VL; e++)
            if (vrf[r][e] !== ref_vrf[r][e]) bad++;
      check({tag, " vrf"}, 32'(bad), 32'd0);
   endtask

   // Issue one command and check its whole timeline. Called at a negedge
   // while idle; returns at the negedge of the cycle after done.
   task automatic run_cmd(input logic [8:0] op, input int vs1, input int vs2, input int vd,
                          input int vl, input bit hold_valid, input string name);
      int nrd = 0, nwr = 0, t_done = -1, rd_first = -1, rd_last = -1;
      int wr_first = -1, wr_last = -1;
      logic err_seen = 1'b0;
      bit bad;
      logic [31:0] a_snap [MAX_VL];
      logic [31:0] b_snap [MAX_VL];

      bad = !(op_is_add(op) || op_is_mul(op)) || vl > MAX_VL;
      for (int e = 0; e < MAX_VL; e++) begin
         a_snap[e] = ref_vrf[vs1][e];
         b_snap[e] = ref_vrf[vs2][e];
      end

      check({name, " ready"}, 32'(cmd_if.cmd_ready), 32'd1);
      cmd_if.cmd_op    = op;
      cmd_if.cmd_vs1   = REG_W'(vs1);
      cmd_if.cmd_vs2   = REG_W'(vs2);
      cmd_if.cmd_vd    = REG_W'(vd);
      cmd_if.cmd_vl    = 4'(vl);
      cmd_if.cmd_valid = 1'b1;

      for (int k = 1; k <= 40 && t_done < 0; k++) begin
         @(negedge clk);
         if (!hold_valid) cmd_if.cmd_valid = 1'b0;
         if (rd_en) begin
            if (rd_first < 0) rd_first = k;
            rd_last = k;
            check({name, " rd idx"}, 32'({rd_reg_a, rd_reg_b, rd_elem}),
                  32'({REG_W'(vs1), REG_W'(vs2), ELEM_W'(nrd)}));
            nrd++;
         end
         if (wr_en) begin
            if (wr_first < 0) wr_first = k;
            wr_last = k;
            check({name, " wr idx"}, 32'({wr_reg, wr_elem}), 32'({REG_W'(vd), ELEM_W'(nwr)}));
            nwr++;
         end
         if (done) begin
            t_done   = k;
            err_seen = err;
         end
      end
      cmd_if.cmd_valid = 1'b0;

      if (t_done < 0) check({name, " done timeout"}, 32'd0, 32'd1);

      if (bad || vl == 0) begin
         check({name, " reads"},  32'(nrd),    32'd0);
         check({name, " writes"}, 32'(nwr),    32'd0);
         check({name, " t_done"}, 32'(t_done), 32'd1);
         check({name, " err"},    32'(err_seen), 32'(bad));
      end else begin
         check({name, " reads"},    32'(nrd),      32'(vl));
         check({name, " rd span"},  32'({rd_first[7:0], rd_last[7:0]}), {16'd0, 8'd1, 8'(vl)});
         check({name, " writes"},   32'(nwr),      32'(vl));
         check({name, " wr span"},  32'({wr_first[7:0], wr_last[7:0]}), {16'd0, 8'd2, 8'(vl + 1)});
         check({name, " t_done"},   32'(t_done),   32'(vl + 2));
         check({name, " err"},      32'(err_seen), 32'd0);
         check({name, " alu_a hold"}, alu_a, a_snap[vl-1]);
         check({name, " alu_b hold"}, alu_b, b_snap[vl-1]);
         check({name, " alu_op hold"}, 32'(alu_op), 32'(op));
         for (int e = 0; e < vl; e++) ref_vrf[vd][e] = ref_elem(op, a_snap[e], b_snap[e]);
      end

      @(negedge clk);
      check({name, " ready after"}, 32'(cmd_if.cmd_ready), 32'd1);
      check_vrf(name);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " strobes"}, 32'({rd_en, alu_en, wr_en, done, err, cmd_if.cmd_ready}), 32'd0);
      check({tag, " idx"}, 32'({rd_reg_a, rd_reg_b, rd_elem, wr_reg, wr_elem}), 32'd0);
      check({tag, " wr_data"}, wr_data, 32'd0);
      check({tag, " alu"}, alu_a | alu_b | 32'(alu_op), 32'd0);
   endtask

   // Abort a vl=8 add with reset during its second write.
   task automatic reset_mid_cmd();
      logic [31:0] a_snap [MAX_VL];
      logic [31:0] b_snap [MAX_VL];
      for (int e = 0; e < MAX_VL; e++) begin
         a_snap[e] = ref_vrf[10][e];
         b_snap[e] = ref_vrf[11][e];
      end
      cmd_if.cmd_op    = OP_ADD1;
      cmd_if.cmd_vs1   = 5'd10;
      cmd_if.cmd_vs2   = 5'd11;
      cmd_if.cmd_vd    = 5'd12;
      cmd_if.cmd_vl    = 4'd8;
      cmd_if.cmd_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         cmd_if.cmd_valid = 1'b0;
      end
      check("rst write2", 32'({wr_en, wr_elem}), 32'({1'b1, 3'd1}));
      nrst = 1'b0;
      for (int e = 0; e < 2; e++) ref_vrf[12][e] = ref_elem(OP_ADD1, a_snap[e], b_snap[e]);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_outputs_zero("rst mid");
      end
      nrst = 1'b1;
      @(negedge clk);
      check("rst ready", 32'(cmd_if.cmd_ready), 32'd1);
      check_vrf("rst mid");
   endtask

   initial begin
      logic [31:0] v;
      logic [8:0]  rop;
      int          sel;

      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = '0;
      cmd_if.cmd_vs1   = '0;
      cmd_if.cmd_vs2   = '0;
      cmd_if.cmd_vd    = '0;
      cmd_if.cmd_vl    = '0;
      for (int r = 0; r < NUM_REGS; r++)
         for (int e = 0; e < MAX_VL; e++) begin
            v = $urandom;
            vrf[r][e]     = v;
            ref_vrf[r][e] = v;
         end

      // Reset state
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      nrst = 1'b1;
      @(negedge clk);
      check("reset release ready", 32'(cmd_if.cmd_ready), 32'd1);

      // Directed add
      for (int e = 0; e < 4; e++) begin
         vrf[1][e] = 32'(e + 1);       ref_vrf[1][e] = 32'(e + 1);
         vrf[2][e] = 32'(10 * (e + 1)); ref_vrf[2][e] = 32'(10 * (e + 1));
      end
      run_cmd(OP_ADD0, 1, 2, 3, 4, 1'b0, "add");
      check("add r3[0]", vrf[3][0], 32'd11);
      check("add r3[3]", vrf[3][3], 32'd44);

      // Directed multiply with truncation
      for (int e = 0; e < MAX_VL; e++) begin
         vrf[1][e] = 32'h0001_0000; ref_vrf[1][e] = 32'h0001_0000;
         vrf[2][e] = 32'h0001_0001; ref_vrf[2][e] = 32'h0001_0001;
      end
      run_cmd(OP_MUL1, 1, 2, 3, MAX_VL, 1'b0, "mul");
      check("mul r3[7]", vrf[3][7], 32'h0001_0000);

      // Rejected and empty commands, back to back
      run_cmd(9'h001, 1, 2, 3, 4, 1'b0, "illegal op");
      run_cmd(OP_ADD0, 1, 2, 3, MAX_VL + 1, 1'b0, "vl too big");
      run_cmd(OP_MUL0, 1, 2, 3, 0, 1'b0, "vl zero");
      run_cmd(OP_ADD1, 4, 4, 7, 2, 1'b0, "after vl zero");

      // Aliasing with cmd_valid held while busy
      for (int e = 0; e < 4; e++) begin
         vrf[5][e] = 32'd1; ref_vrf[5][e] = 32'd1;
         vrf[6][e] = 32'd2; ref_vrf[6][e] = 32'd2;
      end
      run_cmd(OP_ADD0, 5, 6, 5, 4, 1'b1, "alias");
      check("alias r5[2]", vrf[5][2], 32'd3);

      // Reset in the middle of a command, then a normal command
      reset_mid_cmd();
      run_cmd(OP_MUL0, 12, 13, 14, 5, 1'b0, "post reset");

      // Randomized commands
      for (int n = 0; n < 30; n++) begin
         sel = int'($urandom_range(0, 4));
         case (sel)
            0: rop = OP_ADD0;
            1: rop = OP_ADD1;
            2: rop = OP_MUL0;
            3: rop = OP_MUL1;
            default: rop = 9'($urandom);
         endcase
         run_cmd(rop, int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, NUM_REGS - 1)),
                 int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, MAX_VL + 1)),
                 1'($urandom), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
